// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with byte-enabled write port,
// two combinational read ports, optional hardwired-zero R0, optional
// write-to-read bypass and a one-cycle shadow snapshot/restore bank.
module reg_file_param #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned ZERO_R0 = 1,
  parameter int unsigned BYPASS  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wbe,
  input  logic [AW-1:0]      raddr_a,
  output logic [WIDTH-1:0]   rdata_a,
  input  logic [AW-1:0]      raddr_b,
  output logic [WIDTH-1:0]   rdata_b,
  input  logic               snap,
  input  logic               restore
);

  localparam int unsigned NB = WIDTH / 8;

  typedef logic [WIDTH-1:0] word_t;

  word_t regs       [DEPTH];
  word_t shadow     [DEPTH];
  word_t regs_nxt   [DEPTH];
  word_t shadow_nxt [DEPTH];

  logic  wr_eff;
  logic  hit_a;
  logic  hit_b;
  word_t stored_a;
  word_t stored_b;

  // Replace the enabled byte lanes of old_v with those of new_v.
  function automatic word_t lane_merge(input word_t old_v, input word_t new_v,
                                       input logic [NB-1:0] be);
    word_t r;
    r = old_v;
    for (int unsigned b = 0; b < NB; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  // A write only takes effect when restore is idle and the target is a real, writable register.
  assign wr_eff = we && !restore && in_range(waddr) && !is_zero_reg(waddr);
  assign hit_a  = (BYPASS != 0) && wr_eff && (raddr_a == waddr);
  assign hit_b  = (BYPASS != 0) && wr_eff && (raddr_b == waddr);

  // Stored-value lookup for both read ports; out-of-range and hardwired R0 read zero.
  always_comb begin
    stored_a = '0;
    stored_b = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!((ZERO_R0 != 0) && (i == 0))) begin
        if (raddr_a == AW'(i)) stored_a = regs[i];
        if (raddr_b == AW'(i)) stored_b = regs[i];
      end
    end
  end

  // Read ports with optional forwarding of this cycle's effective write.
  always_comb begin
    rdata_a = hit_a ? lane_merge(stored_a, wdata, wbe) : stored_a;
    rdata_b = hit_b ? lane_merge(stored_b, wdata, wbe) : stored_b;
  end

  // Next-state for registers and shadow; snapshot reads pre-write values, restore overrides writes.
  always_comb begin
    regs_nxt   = regs;
    shadow_nxt = shadow;
    if (snap) shadow_nxt = regs;
    if (restore) begin
      regs_nxt = shadow;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_eff && (waddr == AW'(i))) regs_nxt[i] = lane_merge(regs[i], wdata, wbe);
      end
    end
    if (ZERO_R0 != 0) regs_nxt[0] = '0;
  end

  // State update with asynchronous active-low clear of both banks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs   <= '{default: '0};
      shadow <= '{default: '0};
    end else begin
      regs   <= regs_nxt;
      shadow <= shadow_nxt;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Testbench for reg_file_param: two builds (ZERO_R0=1/BYPASS=1 and
// ZERO_R0=0/BYPASS=0) driven in parallel; expected values are queued as
// stimulus is applied and compared once the read ports have settled.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic [1:0]  wbe;
  logic [3:0]  raddr_a;
  logic [3:0]  raddr_b;
  logic        snap;
  logic        restore;
  logic [15:0] ra1, rb1, ra0, rb0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       nm;
    int          port;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  reg_file_param #(.WIDTH(16), .DEPTH(8), .AW(4), .ZERO_R0(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr_a(raddr_a), .rdata_a(ra1), .raddr_b(raddr_b), .rdata_b(rb1),
    .snap(snap), .restore(restore)
  );

  reg_file_param #(.WIDTH(16), .DEPTH(8), .AW(4), .ZERO_R0(0), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr_a(raddr_a), .rdata_a(ra0), .raddr_b(raddr_b), .rdata_b(rb0),
    .snap(snap), .restore(restore)
  );

  // port 0/1: bypass build A/B, port 2/3: plain build A/B
  task automatic expect_val(input string nm, input int port, input logic [15:0] e);
    exp_t t;
    t.nm = nm;
    t.port = port;
    t.exp = e;
    sb.push_back(t);
  endtask

  task automatic expect_all(input string nm, input logic [15:0] e);
    for (int p = 0; p < 4; p++) expect_val(nm, p, e);
  endtask

  function automatic logic [15:0] observe(input int port);
    case (port)
      0:       return ra1;
      1:       return rb1;
      2:       return ra0;
      default: return rb0;
    endcase
  endfunction

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    we = 1'b1; waddr = a; wdata = d; wbe = be;
    edge_step();
    we = 1'b0; wbe = 2'b00;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [15:0] obs;
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin
          raddr_a = 4'd3; raddr_b = 4'd3;
          expect_all("reset_initial", 16'h0000);
        end
        1: begin
          rst = 1'b1;
          wr(4'd3, 16'hBEEF, 2'b11);
          snap = 1'b1; edge_step(); snap = 1'b0;
          expect_all("reset_load_r3", 16'hBEEF);
        end
        2: begin
          #1 rst = 1'b0;
          expect_all("reset_async_clear", 16'h0000);
        end
        default: begin
          rst = 1'b1;
          restore = 1'b1; edge_step(); restore = 1'b0;
          expect_all("reset_shadow_clear", 16'h0000);
        end
      endcase
      #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.port);
        total++;
        if (obs !== e.exp) begin
          bad++;
          $display("FAIL %s port%0d: got %h expected %h", e.nm, e.port, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_byte_en();
    exp_t e;
    logic [15:0] obs;
    raddr_a = 4'd2; raddr_b = 4'd2;
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin wr(4'd2, 16'h1234, 2'b11); expect_all("be_full", 16'h1234); end
        1: begin wr(4'd2, 16'hABCD, 2'b01); expect_all("be_low", 16'h12CD); end
        2: begin wr(4'd2, 16'hFFFF, 2'b00); expect_all("be_none", 16'h12CD); end
        default: begin wr(4'd2, 16'h5600, 2'b10); expect_all("be_high", 16'h56CD); end
      endcase
      #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.port);
        total++;
        if (obs !== e.exp) begin
          bad++;
          $display("FAIL %s port%0d: got %h expected %h", e.nm, e.port, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_zero_range();
    exp_t e;
    logic [15:0] obs;
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin
          we = 1'b1; waddr = 4'd0; wdata = 16'hFFFF; wbe = 2'b11;
          raddr_a = 4'd0; raddr_b = 4'd9;
          expect_all("r0_write_pending", 16'h0000);
        end
        1: begin
          edge_step(); we = 1'b0;
          expect_val("r0_zero", 0, 16'h0000);
          expect_val("r0_oor9", 1, 16'h0000);
          expect_val("r0_plain", 2, 16'hFFFF);
          expect_val("r0_oor9", 3, 16'h0000);
        end
        2: begin
          we = 1'b1; waddr = 4'd9; wdata = 16'h7777; wbe = 2'b11;
          raddr_a = 4'd9; raddr_b = 4'd1;
          expect_all("oor_write_pending", 16'h0000);
        end
        default: begin
          edge_step(); we = 1'b0; raddr_a = 4'd15;
          expect_all("oor_write_ignored", 16'h0000);
        end
      endcase
      #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.port);
        total++;
        if (obs !== e.exp) begin
          bad++;
          $display("FAIL %s port%0d: got %h expected %h", e.nm, e.port, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [15:0] obs;
    for (int ph = 0; ph < 5; ph++) begin
      case (ph)
        0: begin
          raddr_a = 4'd5; raddr_b = 4'd5;
          wr(4'd5, 16'h00FF, 2'b11);
          expect_all("byp_init", 16'h00FF);
        end
        1: begin
          we = 1'b1; waddr = 4'd5; wdata = 16'hAA00; wbe = 2'b10;
          expect_val("byp_fwd", 0, 16'hAAFF);
          expect_val("byp_fwd", 1, 16'hAAFF);
          expect_val("nobyp_old", 2, 16'h00FF);
          expect_val("nobyp_old", 3, 16'h00FF);
        end
        2: begin
          edge_step(); we = 1'b0; wbe = 2'b00;
          expect_all("byp_after_edge", 16'hAAFF);
        end
        3: begin
          we = 1'b1; waddr = 4'd5; wdata = 16'h0011; wbe = 2'b01;
          raddr_b = 4'd2;
          expect_val("byp_port_a", 0, 16'hAA11);
          expect_val("byp_port_b_miss", 1, 16'h56CD);
          expect_val("nobyp_a", 2, 16'hAAFF);
          expect_val("nobyp_b", 3, 16'h56CD);
        end
        default: begin
          edge_step(); we = 1'b0; wbe = 2'b00; raddr_b = 4'd5;
          expect_all("byp_low_after_edge", 16'hAA11);
        end
      endcase
      #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.port);
        total++;
        if (obs !== e.exp) begin
          bad++;
          $display("FAIL %s port%0d: got %h expected %h", e.nm, e.port, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_snap_restore();
    exp_t e;
    logic [15:0] obs;
    for (int ph = 0; ph < 7; ph++) begin
      case (ph)
        0: begin
          raddr_a = 4'd1; raddr_b = 4'd5;
          wr(4'd1, 16'h0001, 2'b11);
          snap = 1'b1; edge_step(); snap = 1'b0;
          expect_val("snap_r1", 0, 16'h0001);
          expect_val("snap_r1", 2, 16'h0001);
        end
        1: begin
          wr(4'd1, 16'h0777, 2'b11);
          expect_val("post_snap_write", 0, 16'h0777);
          expect_val("post_snap_write", 2, 16'h0777);
        end
        2: begin
          restore = 1'b1; edge_step(); restore = 1'b0;
          expect_val("restore_r1", 0, 16'h0001);
          expect_val("restore_r1", 2, 16'h0001);
          expect_val("restore_r5", 1, 16'hAA11);
          expect_val("restore_r5", 3, 16'hAA11);
        end
        3: begin
          restore = 1'b1; we = 1'b1; waddr = 4'd1; wdata = 16'h5555; wbe = 2'b11;
          expect_val("restore_no_bypass", 0, 16'h0001);
          expect_val("restore_no_bypass", 2, 16'h0001);
        end
        4: begin
          edge_step(); we = 1'b0; wbe = 2'b00; restore = 1'b0;
          expect_val("restore_drops_write", 0, 16'h0001);
          expect_val("restore_drops_write", 2, 16'h0001);
        end
        5: begin
          snap = 1'b1; we = 1'b1; waddr = 4'd1; wdata = 16'h0999; wbe = 2'b11;
          edge_step(); snap = 1'b0; we = 1'b0; wbe = 2'b00;
          expect_val("snap_with_write", 0, 16'h0999);
          expect_val("snap_with_write", 2, 16'h0999);
        end
        default: begin
          raddr_b = 4'd0;
          restore = 1'b1; edge_step(); restore = 1'b0;
          expect_val("snap_took_prewrite", 0, 16'h0001);
          expect_val("snap_took_prewrite", 2, 16'h0001);
          expect_val("restore_r0_zero", 1, 16'h0000);
          expect_val("restore_r0_plain", 3, 16'hFFFF);
        end
      endcase
      #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.port);
        total++;
        if (obs !== e.exp) begin
          bad++;
          $display("FAIL %s port%0d: got %h expected %h", e.nm, e.port, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_swap();
    exp_t e;
    logic [15:0] obs;
    for (int ph = 0; ph < 3; ph++) begin
      case (ph)
        0: begin
          raddr_a = 4'd4; raddr_b = 4'd4;
          wr(4'd4, 16'h0040, 2'b11);
          snap = 1'b1; edge_step(); snap = 1'b0;
          wr(4'd4, 16'h0004, 2'b11);
          expect_all("swap_pre", 16'h0004);
        end
        1: begin
          snap = 1'b1; restore = 1'b1; edge_step(); snap = 1'b0; restore = 1'b0;
          expect_all("swap_regs", 16'h0040);
        end
        default: begin
          restore = 1'b1; edge_step(); restore = 1'b0;
          expect_all("swap_shadow", 16'h0004);
        end
      endcase
      #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.port);
        total++;
        if (obs !== e.exp) begin
          bad++;
          $display("FAIL %s port%0d: got %h expected %h", e.nm, e.port, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [15:0] obs;
    logic [15:0] d [8];
    for (int ph = 0; ph < 8; ph++) begin
      if (ph == 0) begin
        for (int a = 1; a < 8; a++) begin
          d[a] = 16'($urandom);
          wr(4'(a), d[a], 2'b11);
        end
      end else begin
        raddr_a = 4'(ph);
        raddr_b = 4'(8 - ph);
        expect_val("b2b_a", 0, d[ph]);
        expect_val("b2b_b", 1, d[8 - ph]);
        expect_val("b2b_a", 2, d[ph]);
        expect_val("b2b_b", 3, d[8 - ph]);
      end
      #1;
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.port);
        total++;
        if (obs !== e.exp) begin
          bad++;
          $display("FAIL %s port%0d: got %h expected %h", e.nm, e.port, obs, e.exp);
        end
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wbe = '0;
    raddr_a = '0; raddr_b = '0; snap = 1'b0; restore = 1'b0;
    #2;
    test_reset();
    test_byte_en();
    test_zero_range();
    test_bypass();
    test_snap_restore();
    test_swap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
